// File: rtl/wave_pkg.sv
// Shared types and helpers for the waveform capture writer.
package wave_pkg;

   typedef enum logic [2:0] {
      StStartup,
      StIdle,
      StWait,
      StAddr,
      StData,
      StDone
   } wave_state_e;

   localparam int unsigned BEAT_COUNT   = 4;
   localparam int unsigned BURST_STRIDE = 8;
   localparam int unsigned STRIDE_SHIFT = $clog2(BURST_STRIDE);

   // One captured sample set; a0 goes out on beat 0, b1 on beat 3.
   typedef struct packed {
      logic [11:0] a0;
      logic [11:0] a1;
      logic [11:0] b0;
      logic [11:0] b1;
      logic [15:0] aux;
   } sample_set_t;

   // Beat layout expected by the display unpacker.
   function automatic logic [17:0] pack_beat(input sample_set_t set, input logic [1:0] beat);
      logic [11:0] s;
      logic [3:0]  nib;
      s   = set.a0;
      nib = set.aux[15:12];
      case (beat)
         2'd1: begin s = set.a1; nib = set.aux[11:8]; end
         2'd2: begin s = set.b0; nib = set.aux[7:4];  end
         2'd3: begin s = set.b1; nib = set.aux[3:0];  end
         default: ;
      endcase
      return {1'b0, nib, s[11:8], 1'b0, s[7:0]};
   endfunction

endpackage

// File: rtl/wave_sample_hold.sv
// Decimation counter plus single-entry holding register for kept sample sets.
// With WAVE_TESTPAT_EN defined, a 12-bit ramp replaces the ADC channels.
module wave_sample_hold
   import wave_pkg::*;
#(
   parameter int unsigned DECIMATE = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        start_i,
   input  logic        flush_i,
   input  logic        active_i,
   input  logic        strobe_i,
   input  sample_set_t sample_i,
   input  logic        pop_i,
   output logic        load_o,
   output logic        full_o,
   output sample_set_t data_o,
   output logic        overflow_o
);

   localparam logic [15:0] LastCount = 16'(DECIMATE - 1);

   logic [15:0] dcnt_q, dcnt_d;
   logic        full_q, full_d;
   logic        ovf_q, ovf_d;
   sample_set_t hold_q, hold_d;
   sample_set_t set_in;
   logic        keep;

   assign keep = active_i && strobe_i && (dcnt_q == LastCount);
   // A pop in the same cycle frees the slot for the incoming set.
   assign load_o = keep && (!full_q || pop_i);

`ifdef WAVE_TESTPAT_EN
   logic [11:0] ramp_q, ramp_d;

   // Ramp value for the set being kept; channels spaced 256 apart.
   always_comb begin
      set_in.a0  = ramp_q;
      set_in.a1  = ramp_q + 12'h100;
      set_in.b0  = ramp_q + 12'h200;
      set_in.b1  = ramp_q + 12'h300;
      set_in.aux = sample_i.aux;
      ramp_d     = ramp_q;
      if (keep) ramp_d = ramp_q + 12'd1;
      if (start_i) ramp_d = '0;
   end

   // Ramp register restarts at every arm.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) ramp_q <= '0;
      else         ramp_q <= ramp_d;
   end
`else
   // Real ADC inputs feed the holding register directly.
   always_comb begin
      set_in = sample_i;
   end
`endif

   // Next-state for counter, holding register and sticky overflow.
   always_comb begin
      dcnt_d = dcnt_q;
      full_d = full_q;
      hold_d = hold_q;
      ovf_d  = ovf_q;
      if (active_i && strobe_i) dcnt_d = keep ? '0 : dcnt_q + 16'd1;
      if (pop_i) full_d = 1'b0;
      if (load_o) begin
         full_d = 1'b1;
         hold_d = set_in;
      end
      if (keep && !load_o) ovf_d = 1'b1;
      if (start_i) begin
         dcnt_d = '0;
         full_d = 1'b0;
         ovf_d  = 1'b0;
      end
      // An abandoned capture must not leak a stale set into the next one.
      if (flush_i) begin
         dcnt_d = '0;
         full_d = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dcnt_q <= '0;
         full_q <= 1'b0;
         ovf_q  <= 1'b0;
         hold_q <= '0;
      end else begin
         dcnt_q <= dcnt_d;
         full_q <= full_d;
         ovf_q  <= ovf_d;
         hold_q <= hold_d;
      end
   end

   assign full_o     = full_q;
   assign data_o     = hold_q;
   assign overflow_o = ovf_q;

endmodule

// File: rtl/wave_capture_writer.sv
// PSRAM write initiator filling the waveform capture buffer with 4-beat bursts.
// Optional build macro: WAVE_TESTPAT_EN (ramp test pattern instead of ADC data).
module wave_capture_writer
   import wave_pkg::*;
#(
   parameter int unsigned NUM_BURSTS = 800,
   parameter logic [24:0] BASE_ADDR  = 25'h0,
   parameter int unsigned DECIMATE   = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        psram_ready,
   input  logic        arm,
   input  logic [11:0] ad_a0,
   input  logic [11:0] ad_a1,
   input  logic [11:0] ad_b0,
   input  logic [11:0] ad_b1,
   input  logic [15:0] ad_aux,
   input  logic        ad_strobe,
   output logic [24:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [17:0] wdata,
   output logic        wvalid,
   input  logic        wready,
   output logic        wlast,
   output logic        busy,
   output logic        done,
   output logic        overflow,
   output logic [21:0] burst_cnt
);

   localparam logic [21:0] LastBurst = 22'(NUM_BURSTS - 1);
   localparam logic [1:0]  LastBeat  = 2'(BEAT_COUNT - 1);

   wave_state_e state_q, state_d;
   logic [21:0] burst_cnt_q, burst_cnt_d;
   logic [1:0]  beat_q, beat_d;
   sample_set_t burst_q, burst_d;
   logic        done_q, done_d;

   sample_set_t sample_in;
   sample_set_t hold_data;
   logic        hold_full;
   logic        hold_load;
   logic        start;
   logic        flush;
   logic        pop;

   assign sample_in = {ad_a0, ad_a1, ad_b0, ad_b1, ad_aux};
   assign busy      = (state_q == StWait) || (state_q == StAddr) || (state_q == StData);
   assign awvalid   = (state_q == StAddr);
   assign wvalid    = (state_q == StData);
   assign wlast     = wvalid && (beat_q == LastBeat);
   assign wdata     = pack_beat(burst_q, beat_q);
   assign awaddr    = BASE_ADDR + (25'(burst_cnt_q) << STRIDE_SHIFT);
   assign pop       = awvalid && awready;
   assign done      = done_q;
   assign burst_cnt = burst_cnt_q;

   wave_sample_hold #(
      .DECIMATE (DECIMATE)
   ) u_sample_hold (
      .clk_i      (clk),
      .rst_ni     (reset),
      .start_i    (start),
      .flush_i    (flush),
      .active_i   (busy),
      .strobe_i   (ad_strobe),
      .sample_i   (sample_in),
      .pop_i      (pop),
      .load_o     (hold_load),
      .full_o     (hold_full),
      .data_o     (hold_data),
      .overflow_o (overflow)
   );

   // Burst FSM next-state; losing psram_ready overrides everything.
   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      beat_d      = beat_q;
      burst_d     = burst_q;
      done_d      = done_q;
      start       = 1'b0;
      flush       = 1'b0;
      if (!psram_ready) begin
         state_d = StStartup;
         flush   = 1'b1;
      end else begin
         case (state_q)
            StStartup: state_d = StIdle;
            StIdle: begin
               if (arm) begin
                  state_d     = StWait;
                  burst_cnt_d = '0;
                  done_d      = 1'b0;
                  start       = 1'b1;
               end
            end
            // Looking at the load too saves a cycle of address latency.
            StWait: if (hold_full || hold_load) state_d = StAddr;
            StAddr: begin
               if (awready) begin
                  state_d = StData;
                  beat_d  = '0;
                  burst_d = hold_data;
               end
            end
            StData: begin
               if (wready) begin
                  if (beat_q == LastBeat) begin
                     beat_d      = '0;
                     burst_cnt_d = burst_cnt_q + 22'd1;
                     if (burst_cnt_q == LastBurst) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                     end else begin
                        state_d = StWait;
                     end
                  end else begin
                     beat_d = beat_q + 2'd1;
                  end
               end
            end
            StDone: state_d = StIdle;
            default: state_d = StStartup;
         endcase
      end
   end

   // FSM and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StStartup;
         burst_cnt_q <= '0;
         beat_q      <= '0;
         burst_q     <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         beat_q      <= beat_d;
         burst_q     <= burst_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_wave_capture_writer.sv
// Randomized scoreboard bench for wave_capture_writer.
module tb_wave_capture_writer;

   localparam int unsigned NB   = 4;
   localparam int unsigned DEC  = 3;
   localparam logic [24:0] BASE = 25'h1FFFFF0;

   logic        clk, reset, psram_ready, arm, ad_strobe;
   logic [11:0] ad_a0, ad_a1, ad_b0, ad_b1;
   logic [15:0] ad_aux;
   logic [24:0] awaddr;
   logic        awvalid, awready, wvalid, wready, wlast, busy, done, overflow;
   logic [17:0] wdata;
   logic [21:0] burst_cnt;

   wave_capture_writer #(
      .NUM_BURSTS (NB),
      .BASE_ADDR  (BASE),
      .DECIMATE   (DEC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .psram_ready (psram_ready),
      .arm         (arm),
      .ad_a0       (ad_a0),
      .ad_a1       (ad_a1),
      .ad_b0       (ad_b0),
      .ad_b1       (ad_b1),
      .ad_aux      (ad_aux),
      .ad_strobe   (ad_strobe),
      .awaddr      (awaddr),
      .awvalid     (awvalid),
      .awready     (awready),
      .wdata       (wdata),
      .wvalid      (wvalid),
      .wready      (wready),
      .wlast       (wlast),
      .busy        (busy),
      .done        (done),
      .overflow    (overflow),
      .burst_cnt   (burst_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [24:0] addr;
      logic [11:0] c0, c1, c2, c3;
      logic [15:0] aux;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Expected beat from the documented layout, by arithmetic.
   function automatic logic [17:0] ref_beat(input exp_t e, input int k);
      int s, nib;
      case (k)
         0: s = int'(e.c0);
         1: s = int'(e.c1);
         2: s = int'(e.c2);
         default: s = int'(e.c3);
      endcase
      nib = int'(e.aux >> (12 - 4 * k)) & 15;
      return 18'((nib * 16 + s / 256) * 512 + s % 256);
   endfunction

   // ---------------- reference model ----------------
   bit m_active = 0;
   bit m_full = 0;
   bit exp_ovf = 0;
   int m_dcnt = 0;
   int m_acc = 0;
   int m_beats = 0;

   always @(negedge clk) begin
      bit   aw_hs, kept_ok;
      exp_t e;
      if (!reset || !psram_ready) begin
         m_active = 0;
         m_full   = 0;
         if (!reset) exp_ovf = 0;
         exp_q.delete();
      end else begin
         aw_hs   = awvalid && awready;
         kept_ok = 0;
         if (m_active && ad_strobe) begin
            if (m_dcnt == int'(DEC) - 1) begin
               m_dcnt = 0;
               if (m_full && !aw_hs) begin
                  exp_ovf = 1;
               end else begin
                  e.addr = BASE + 25'(m_acc * 8);
                  e.c0 = ad_a0; e.c1 = ad_a1; e.c2 = ad_b0; e.c3 = ad_b1;
                  e.aux = ad_aux;
                  exp_q.push_back(e);
                  m_acc++;
                  kept_ok = 1;
               end
            end else begin
               m_dcnt++;
            end
         end
         m_full = kept_ok ? 1'b1 : (aw_hs ? 1'b0 : m_full);
         if (m_active && wvalid && wready) begin
            m_beats++;
            if (m_beats == int'(NB) * 4) m_active = 0;
         end
         if (arm && !m_active) begin
            m_active = 1; m_full = 0; m_dcnt = 0; m_acc = 0; m_beats = 0; exp_ovf = 0;
            exp_q.delete();
         end
      end
   end

   // ---------------- monitor ----------------
   exp_t        cur;
   bit          have_cur = 0;
   int          mon_beat = 0;
   bit          aw_stall = 0, w_stall = 0;
   logic [24:0] last_addr;
   logic [17:0] last_wdata;

   always @(negedge clk) begin
      if (!reset || !psram_ready) begin
         have_cur = 0; mon_beat = 0; aw_stall = 0; w_stall = 0;
      end else begin
         if (aw_stall && awvalid) check("awaddr_stable", 32'(awaddr), 32'(last_addr));
         if (w_stall && wvalid) check("wdata_stable", 32'(wdata), 32'(last_wdata));
         if (awvalid && awready) begin
            if (exp_q.size() == 0) begin
               check("aw_unexpected", 32'(awvalid), 32'd0);
            end else begin
               cur = exp_q.pop_front();
               have_cur = 1;
               mon_beat = 0;
               check("awaddr", 32'(awaddr), 32'(cur.addr));
            end
         end
         if (wvalid) check("wlast", 32'(wlast), 32'(mon_beat == 3));
         if (wvalid && wready) begin
            if (!have_cur) begin
               check("w_unexpected", 32'(wvalid), 32'd0);
            end else begin
               check($sformatf("wdata_beat%0d", mon_beat), 32'(wdata),
                     32'(ref_beat(cur, mon_beat)));
               mon_beat++;
               if (mon_beat == 4) begin
                  have_cur = 0;
                  mon_beat = 0;
               end
            end
         end
         aw_stall   = awvalid && !awready;
         w_stall    = wvalid && !wready;
         last_addr  = awaddr;
         last_wdata = wdata;
      end
   end

   // ---------------- stimulus ----------------
   int strobe_pct = 0, awr_pct = 100, wr_pct = 100;
   bit wr_toggle = 0, fixed_pat = 0;

   task automatic step();
      @(posedge clk);
      #1;
      arm       = 1'b0;
      ad_strobe = ($urandom_range(99) < strobe_pct);
      ad_a0     = fixed_pat ? 12'hABC : 12'($urandom);
      ad_a1     = 12'($urandom);
      ad_b0     = 12'($urandom);
      ad_b1     = 12'($urandom);
      ad_aux    = fixed_pat ? 16'h5000 : 16'($urandom);
      awready   = ($urandom_range(99) < awr_pct);
      wready    = wr_toggle ? ~wready : ($urandom_range(99) < wr_pct);
   endtask

   task automatic do_arm();
      step();
      step();
      arm = 1'b1;
      step();
   endtask

   task automatic wait_done(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         step();
         if (done) break;
      end
      check("done", 32'(done), 32'd1);
      check("busy_at_done", 32'(busy), 32'd0);
      check("burst_cnt", 32'(burst_cnt), 32'(NB));
      check("overflow", 32'(overflow), 32'(exp_ovf));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_awvalid"}, 32'(awvalid), 32'd0);
      check({tag, "_wvalid"}, 32'(wvalid), 32'd0);
      check({tag, "_wlast"}, 32'(wlast), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
      check({tag, "_burst_cnt"}, 32'(burst_cnt), 32'd0);
      check({tag, "_awaddr"}, 32'(awaddr), 32'(BASE));
      check({tag, "_wdata"}, 32'(wdata), 32'd0);
   endtask

   initial begin
      bit found;
      reset = 1'b0; psram_ready = 1'b0; arm = 1'b0; ad_strobe = 1'b0;
      ad_a0 = '0; ad_a1 = '0; ad_b0 = '0; ad_b1 = '0; ad_aux = '0;
      awready = 1'b1; wready = 1'b1;
      #3;
      check_reset_outputs("reset");
      step();
      step();
      reset = 1'b1;
      psram_ready = 1'b1;
      strobe_pct = 40;
      for (int i = 0; i < 6; i++) step();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_overflow", 32'(overflow), 32'd0);

      // Fixed pattern, free-flowing handshakes.
      fixed_pat = 1; strobe_pct = 25; awr_pct = 100; wr_pct = 100;
      do_arm();
      check("busy_after_arm", 32'(busy), 32'd1);
      wait_done(600);
      for (int i = 0; i < 3; i++) step();
      check("done_sticky", 32'(done), 32'd1);

      // Random traffic and an arm while busy that must be ignored.
      fixed_pat = 0; strobe_pct = 60; awr_pct = 60; wr_pct = 50;
      do_arm();
      check("done_cleared_on_arm", 32'(done), 32'd0);
      for (int i = 0; i < 8; i++) step();
      arm = 1'b1;
      wait_done(800);

      // Address stall while sets keep arriving.
      strobe_pct = 100; awr_pct = 0; wr_pct = 100;
      do_arm();
      for (int i = 0; i < 20; i++) step();
      check("overflow_during_stall", 32'(overflow), 32'd1);
      awr_pct = 100; strobe_pct = 30;
      wait_done(800);
      check("overflow_kept", 32'(overflow), 32'd1);

      // Alternating wready.
      strobe_pct = 25; wr_toggle = 1;
      do_arm();
      wait_done(800);
      wr_toggle = 0;

      // Lose psram_ready while beat 2 is pending.
      strobe_pct = 100; awr_pct = 100; wr_pct = 100;
      do_arm();
      found = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (wvalid && mon_beat == 2) begin
            found = 1;
            break;
         end
      end
      check("abort_reached_beat2", 32'(found), 32'd1);
      psram_ready = 1'b0; wready = 1'b0; wr_pct = 0;
      step();
      check("abort_wvalid", 32'(wvalid), 32'd0);
      check("abort_awvalid", 32'(awvalid), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      step();
      psram_ready = 1'b1; wr_pct = 100;
      for (int i = 0; i < 3; i++) step();
      do_arm();
      found = 0;
      for (int i = 0; i < 100; i++) begin
         if (awvalid) begin
            found = 1;
            break;
         end
         step();
      end
      check("rearm_awvalid", 32'(found), 32'd1);
      check("rearm_awaddr", 32'(awaddr), 32'(BASE));
      wait_done(800);

      // Asynchronous reset in the middle of a capture.
      strobe_pct = 100; awr_pct = 70; wr_pct = 70;
      do_arm();
      for (int i = 0; i < 15; i++) step();
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) step();
      strobe_pct = 40;
      do_arm();
      wait_done(800);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
